// File: rtl/synth_param_bank_if.sv
// CC write and preset command bus for synth_param_bank.
// The master drives requests; the slave (the parameter bank) returns ready/busy.
interface synth_param_bank_if #(
   parameter int PERCENT_WIDTH = 7,
   parameter int NUM_PRESETS   = 8
);
   localparam int SLOT_W = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1;

   logic                     cc_valid;
   logic                     cc_ready;
   logic [6:0]               cc_number;
   logic [PERCENT_WIDTH-1:0] cc_value;
   logic                     preset_valid;
   logic                     preset_save;
   logic [SLOT_W-1:0]        preset_index;
   logic                     preset_busy;

   modport master (
      output cc_valid, cc_number, cc_value, preset_valid, preset_save, preset_index,
      input  cc_ready, preset_busy
   );

   modport slave (
      input  cc_valid, cc_number, cc_value, preset_valid, preset_save, preset_index,
      output cc_ready, preset_busy
   );
endinterface

// File: rtl/synth_param_bank.sv
// Runtime synth parameter store: CC writes land in a shadow bank, committed to the active bank on sample ticks.
// Optional PARAM_SLEW_EN: each commit moves every active value at most one LSB toward the shadow value.
module synth_param_bank #(
   parameter int NUM_PARAMS    = 16,
   parameter int PERCENT_WIDTH = 7,
   parameter int NUM_PRESETS   = 8,
   parameter int CC_BASE       = 16,
   parameter int DEFAULT_VALUE = 64
) (
   input  logic                                clock,
   input  logic                                reset_l,
   synth_param_bank_if.slave                   bus,
   input  logic                                sample_tick,
   output logic [NUM_PARAMS*PERCENT_WIDTH-1:0] params_out,
   output logic                                params_changed
);
   localparam int IDX_W  = $clog2(NUM_PARAMS);
   localparam int SLOT_W = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1;

   typedef logic [PERCENT_WIDTH-1:0] value_t;
   typedef enum logic [1:0] {IDLE, SAVE, RECALL} state_t;

   localparam value_t DEFAULT_V = value_t'(DEFAULT_VALUE);

   state_t            r_state;
   state_t            w_next;
   logic [IDX_W-1:0]  r_idx;
   logic [SLOT_W-1:0] r_slot;
   logic              r_pending;
   logic              r_changed;
   value_t            r_shadow [NUM_PARAMS];
   value_t            r_active [NUM_PARAMS];
   value_t            r_preset [NUM_PRESETS][NUM_PARAMS];

   value_t            w_nextActive [NUM_PARAMS];
   logic              w_moved;
   logic              w_stillPending;
   logic              w_slotOk;
   logic              w_start;
   logic              w_lastWord;
   logic              w_ccInRange;
   logic              w_ccWrite;
   logic              w_commit;
   int                w_ccOffset;

   always_ff @(posedge clock) begin
      if (!reset_l) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_slotOk = (int'(bus.preset_index) < NUM_PRESETS);
      w_start  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.preset_valid && w_slotOk) begin
               w_start = 1'b1;
               w_next  = bus.preset_save ? SAVE : RECALL;
            end
         end
         SAVE, RECALL: begin
            if (w_lastWord) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_lastWord      = (r_idx == IDX_W'(NUM_PARAMS - 1));
   assign bus.cc_ready    = (r_state == IDLE);
   assign bus.preset_busy = (r_state != IDLE);

   // Out-of-range controller numbers are still accepted, they simply touch nothing.
   always_comb begin
      w_ccOffset  = int'(bus.cc_number) - CC_BASE;
      w_ccInRange = (w_ccOffset >= 0) && (w_ccOffset < NUM_PARAMS);
      w_ccWrite   = bus.cc_valid && bus.cc_ready && w_ccInRange;
      w_commit    = sample_tick && r_pending && (r_state != RECALL);
   end

   always_comb begin
      w_moved        = 1'b0;
      w_stillPending = 1'b0;
      for (int k = 0; k < NUM_PARAMS; k++) begin
         w_nextActive[k] = r_shadow[k];
`ifdef PARAM_SLEW_EN
         if (r_active[k] < r_shadow[k]) begin
            w_nextActive[k] = r_active[k] + 1'b1;
         end else if (r_active[k] > r_shadow[k]) begin
            w_nextActive[k] = r_active[k] - 1'b1;
         end else begin
            w_nextActive[k] = r_active[k];
         end
         w_stillPending = w_stillPending || (w_nextActive[k] != r_shadow[k]);
`endif
         w_moved = w_moved || (w_nextActive[k] != r_active[k]);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_l) begin
         r_idx     <= '0;
         r_slot    <= '0;
         r_pending <= 1'b0;
         r_changed <= 1'b0;
         for (int k = 0; k < NUM_PARAMS; k++) begin
            r_shadow[k] <= DEFAULT_V;
            r_active[k] <= DEFAULT_V;
            for (int p = 0; p < NUM_PRESETS; p++) begin
               r_preset[p][k] <= DEFAULT_V;
            end
         end
      end else begin
         if (w_start) begin
            r_slot <= SLOT_W'(bus.preset_index);
            r_idx  <= '0;
         end else if (r_state != IDLE) begin
            r_idx <= r_idx + 1'b1;
         end

         if (r_state == SAVE) begin
            r_preset[r_slot][r_idx] <= r_shadow[r_idx];
         end
         if (r_state == RECALL) begin
            r_shadow[r_idx] <= r_preset[r_slot][r_idx];
         end
         if (w_ccWrite) begin
            r_shadow[w_ccOffset[IDX_W-1:0]] <= bus.cc_value;
         end

         if (w_commit) begin
            for (int k = 0; k < NUM_PARAMS; k++) begin
               r_active[k] <= w_nextActive[k];
            end
         end
         r_changed <= w_commit && w_moved;

         // A fresh write or a finished recall re-arms the commit even on a commit edge.
         if (w_commit) begin
            r_pending <= w_stillPending;
         end
         if (w_ccWrite || ((r_state == RECALL) && w_lastWord)) begin
            r_pending <= 1'b1;
         end
      end
   end

   always_comb begin
      params_out = '0;
      for (int k = 0; k < NUM_PARAMS; k++) begin
         params_out[k*PERCENT_WIDTH +: PERCENT_WIDTH] = r_active[k];
      end
   end

   assign params_changed = r_changed;
endmodule

// File: tb/tb_synth_param_bank.sv
// Directed bench for synth_param_bank: reset, CC writes, commits, presets (and slew when PARAM_SLEW_EN is defined).
module tb_synth_param_bank;
   localparam int NP = 16;
   localparam int PW = 7;

   logic                clock;
   logic                reset_l;
   logic                sample_tick;
   logic [NP*PW-1:0]    params_out;
   logic                params_changed;

   int checks;
   int errors;

   synth_param_bank_if #(.PERCENT_WIDTH(PW), .NUM_PRESETS(8)) bus ();

   synth_param_bank #(
      .NUM_PARAMS(NP), .PERCENT_WIDTH(PW), .NUM_PRESETS(8), .CC_BASE(16), .DEFAULT_VALUE(64)
   ) dut (
      .clock(clock),
      .reset_l(reset_l),
      .bus(bus),
      .sample_tick(sample_tick),
      .params_out(params_out),
      .params_changed(params_changed)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] field(input int k);
      return 32'(params_out[k*PW +: PW]);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [6:0] num, input logic [6:0] val, input logic tick);
      bus.cc_valid  = 1'b1;
      bus.cc_number = num;
      bus.cc_value  = val;
      sample_tick   = tick;
      step(1);
      bus.cc_valid  = 1'b0;
      sample_tick   = 1'b0;
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      step(1);
      sample_tick = 1'b0;
   endtask

   task automatic presetCmd(input logic save, input logic [2:0] slot);
      bus.preset_valid = 1'b1;
      bus.preset_save  = save;
      bus.preset_index = slot;
      step(1);
      bus.preset_valid = 1'b0;
   endtask

   initial begin
      int busyCycles;
      int readySeen;
      int changedSeen;
      int pulses;

      checks           = 0;
      errors           = 0;
      reset_l          = 1'b0;
      sample_tick      = 1'b0;
      bus.cc_valid     = 1'b0;
      bus.cc_number    = '0;
      bus.cc_value     = '0;
      bus.preset_valid = 1'b0;
      bus.preset_save  = 1'b0;
      bus.preset_index = '0;
      step(3);
      reset_l = 1'b1;

      checkOutput("rst_cc_ready", 32'(bus.cc_ready), 1);
      checkOutput("rst_busy", 32'(bus.preset_busy), 0);
      checkOutput("rst_changed", 32'(params_changed), 0);
      for (int k = 0; k < NP; k++) begin
         checkOutput($sformatf("rst_field%0d", k), field(k), 64);
      end
      for (int t = 0; t < 3; t++) begin
         tick();
         checkOutput($sformatf("idle_tick%0d_changed", t), 32'(params_changed), 0);
      end
      checkOutput("idle_field0", field(0), 64);

`ifdef PARAM_SLEW_EN
      applyStimulus(7'd16, 7'd67, 1'b0);
      pulses = 0;
      for (int t = 0; t < 5; t++) begin
         tick();
         checkOutput($sformatf("slew_tick%0d_field0", t), field(0), (t < 3) ? 65 + t : 67);
         checkOutput($sformatf("slew_tick%0d_changed", t), 32'(params_changed), (t < 3) ? 1 : 0);
         if (params_changed) pulses++;
      end
      checkOutput("slew_pulses", 32'(pulses), 3);
      checkOutput("slew_field1", field(1), 64);
`else
      applyStimulus(7'd18, 7'd100, 1'b0);
      checkOutput("cc18_shadow_only", field(2), 64);
      tick();
      checkOutput("cc18_field2", field(2), 100);
      checkOutput("cc18_changed", 32'(params_changed), 1);
      step(1);
      checkOutput("cc18_pulse_end", 32'(params_changed), 0);
      tick();
      checkOutput("cc18_second_tick", 32'(params_changed), 0);
      checkOutput("cc18_field2_hold", field(2), 100);

      applyStimulus(7'd15, 7'd5, 1'b0);
      applyStimulus(7'd32, 7'd5, 1'b0);
      tick();
      checkOutput("oor_changed", 32'(params_changed), 0);
      checkOutput("oor_field0", field(0), 64);
      checkOutput("oor_field15", field(15), 64);

      // Field 1 pending, then CC 16 on the tick edge: only field 1 commits now.
      applyStimulus(7'd17, 7'd20, 1'b0);
      applyStimulus(7'd16, 7'd10, 1'b1);
      checkOutput("simul_field1", field(1), 20);
      checkOutput("simul_field0", field(0), 64);
      checkOutput("simul_changed", 32'(params_changed), 1);
      step(4);
      tick();
      checkOutput("simul_next_field0", field(0), 10);
      checkOutput("simul_next_changed", 32'(params_changed), 1);

      applyStimulus(7'd17, 7'd7, 1'b0);
      presetCmd(1'b1, 3'd3);
      busyCycles = 0;
      readySeen  = 0;
      while (bus.preset_busy && busyCycles < 40) begin
         busyCycles++;
         if (bus.cc_ready) readySeen++;
         step(1);
      end
      checkOutput("save_busy_cycles", 32'(busyCycles), 16);
      checkOutput("save_ready_seen", 32'(readySeen), 0);

      applyStimulus(7'd17, 7'd90, 1'b0);
      presetCmd(1'b0, 3'd3);
      busyCycles  = 0;
      readySeen   = 0;
      changedSeen = 0;
      while (bus.preset_busy && busyCycles < 40) begin
         busyCycles++;
         if (bus.cc_ready) readySeen++;
         if (params_changed) changedSeen++;
         sample_tick = (busyCycles == 4);
         step(1);
         sample_tick = 1'b0;
      end
      checkOutput("recall_busy_cycles", 32'(busyCycles), 16);
      checkOutput("recall_ready_seen", 32'(readySeen), 0);
      checkOutput("recall_changed_seen", 32'(changedSeen), 0);
      checkOutput("recall_suppressed_field1", field(1), 20);
      tick();
      checkOutput("recall_field1", field(1), 7);
      checkOutput("recall_field0", field(0), 10);
      checkOutput("recall_field2", field(2), 100);
      checkOutput("recall_changed", 32'(params_changed), 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/synth_param_bank.md
Name: synth_param_bank

Overview:
- Runtime, parametrised store for synth control values. Replaces fixed compile-time settings with per-parameter registers that can be updated live.
- Takes MIDI CC writes from the MIDI decoder into a shadow bank.
- Commits the shadow bank to the active bank on the audio sample tick, so the synthesis pipelines only see parameter changes at sample boundaries.
- Adds save and recall of presets, copied one word per cycle by a small FSM.

Parameters:
- NUM_PARAMS, 16, number of controllable parameters (must be at least 2).
- PERCENT_WIDTH, 7, width of each parameter value (matches CONFIG::percent_t).
- NUM_PRESETS, 8, number of preset slots (CONFIG::RECORD_LENGTH).
- CC_BASE, 16, MIDI CC number mapped to parameter 0. CC_BASE+k maps to parameter k.
- DEFAULT_VALUE, 64, reset value of every parameter and every preset word.

Ports:
- clock  in  1  system clock (50 MHz)
- reset_l  in  1  synchronous active-low reset
- cc_valid  in  1  CC write request
- cc_ready  out  1  CC write accepted this cycle when valid&&ready
- cc_number  in  7  MIDI controller number
- cc_value  in  PERCENT_WIDTH  controller value
- sample_tick  in  1  one-cycle commit strobe at the audio sample rate
- preset_valid  in  1  preset command strobe
- preset_save  in  1  1 = save shadow to slot, 0 = recall slot to shadow
- preset_index  in  $clog2(NUM_PRESETS)  slot number
- preset_busy  out  1  preset FSM active
- params_out  out  NUM_PARAMS*PERCENT_WIDTH  active bank, parameter k at bits [k*PW +: PW]
- params_changed  out  1  one-cycle pulse after a commit that altered any active value

Behaviour:
- Reset (reset_l=0 at a clock edge):
  - Shadow, active and all preset words = DEFAULT_VALUE.
  - FSM goes to IDLE.
  - cc_ready=1, preset_busy=0, params_changed=0, pending=0.
  - Reset mid-SAVE or mid-RECALL aborts the copy; all storage returns to defaults.
- CC write:
  - On cc_valid && cc_ready, if CC_BASE <= cc_number < CC_BASE+NUM_PARAMS, then shadow[cc_number-CC_BASE] <= cc_value and pending <= 1.
  - Out-of-range numbers are accepted and dropped, with no state change.
  - cc_ready = (state == IDLE).
- Commit:
  - On sample_tick with pending=1: active <= shadow in one cycle, then pending <= 0.
  - params_changed = 1 on the following cycle iff active != shadow at the commit edge.
  - sample_tick with pending=0 does nothing.
  - sample_tick during SAVE: the commit proceeds.
  - sample_tick during RECALL: the commit is suppressed and pending is held, so a half-recalled bank is never committed.
- Simultaneous CC write and tick: the commit uses the shadow value from before the edge. The new CC value sets pending and commits on the next tick.
- FSM states IDLE, SAVE, RECALL:
  - IDLE -> SAVE or RECALL on preset_valid. Latch the slot index and set counter i=0.
  - SAVE: each cycle preset[slot][i] <= shadow[i], i++. After i = NUM_PARAMS-1, return to IDLE.
  - RECALL: each cycle shadow[i] <= preset[slot][i], i++. At the last word, set pending <= 1 and return to IDLE.
  - Each copy takes exactly NUM_PARAMS cycles.
  - preset_busy = (state != IDLE).
  - preset_valid while busy is ignored.
  - preset_index >= NUM_PRESETS is ignored and the FSM stays in IDLE.
- Preset storage is registered (no RAM inference is required). Index arithmetic is unsigned with no wrap.

Optional Feature:
PARAM_SLEW_EN
- Defined: each commit moves each active value at most 1 LSB toward shadow.
  - pending stays 1 until active == shadow.
  - params_changed pulses on every commit that moves any value.
  - Movement saturates at 0 and PERCENT_MAX, with no wrap.
- Undefined: active jumps to shadow in one commit, as described above.

Test Plan:
- Release reset, run 3 ticks -> every params_out field = 64, params_changed never asserted, cc_ready=1.
- CC 18 = 100, then tick -> params_out[2] = 100 one cycle after the tick, params_changed pulses once. A second tick gives no pulse.
- CC 15 = 5 and CC 32 = 5 (out of range), then tick -> no field changes, no params_changed.
- CC 16 = 10 on the same edge as a tick, then a tick 5 cycles later -> field 0 = 64 after the first tick and 10 after the second.
- Set field 1 = 7, save slot 3, set field 1 = 90, recall slot 3 -> preset_busy high for 16 cycles each, cc_ready low throughout. Tick inside RECALL is suppressed. Tick after recall gives field 1 = 7.
- PARAM_SLEW_EN: CC 16 = 67, then 5 ticks -> field 0 reads 65, 66, 67, 67, 67 and params_changed pulses 3 times.
